// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: default widths and the
// send sequencer state encoding.
package uart_tx_buffer_pkg;

    // Width of one queued word; must match the downstream transmitter.
    localparam int UART_DATA_WIDTH = 8;

    // Default FIFO depth exponent (16 entries).
    localparam int UART_DEPTH_LOG2 = 4;

    // Send sequencer states: IDLE looks for a word to hand off, WAIT holds
    // the handed-off word until the transmitter reports the frame is done.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer/transmitter-facing signal bundle of the UART transmit buffer.
// The master side is the environment (producer plus transmitter); the slave
// side is the buffer itself.
interface uart_tx_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  send_en;
    logic                  Tx_Done;
    logic                  busy;

    modport master (
        output wr_en,
        output wr_data,
        output Tx_Done,
        input  full,
        input  empty,
        input  level,
        input  overflow,
        input  tx_data,
        input  send_en,
        input  busy
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  Tx_Done,
        output full,
        output empty,
        output level,
        output overflow,
        output tx_data,
        output send_en,
        output busy
    );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous byte FIFO with a registered read port. A pop loads the head
// word into rd_data, which then stays put until the next pop, so it can feed
// the transmitter data input directly.
module sync_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LEVEL_W = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic full_w;
    logic empty_w;
    logic pop;
    logic wr_accept;

    assign full_w  = (level_q == LEVEL_W'(DEPTH));
    assign empty_w = (level_q == '0);

    assign rd_data  = rd_data_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign level    = level_q;
    assign overflow = overflow_q;

    // A write into a full FIFO still lands when a pop frees a slot in the same cycle.
    always_comb begin
        pop        = rd_en && !empty_w;
        wr_accept  = wr_en && (!full_w || pop);
        overflow_d = wr_en && !wr_accept;

        wr_ptr_d  = wr_accept ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d  = pop       ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        rd_data_d = pop       ? mem_q[rd_ptr_q]           : rd_data_q;

        level_d = level_q;
        case ({wr_accept, pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer, level, overflow pulse and read port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: queues producer bytes and hands them one at a time
// to the transmitter, waiting for Tx_Done before issuing the next byte.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2 = UART_DEPTH_LOG2
) (
    input  logic            Clk,
    input  logic            Rst_n,
    uart_tx_buffer_if.slave bus
);

    tx_state_e state_q, state_d;
    logic      send_en_q, send_en_d;
    logic      busy_q, busy_d;
    logic      pop;
    logic      fifo_empty;

    assign bus.empty   = fifo_empty;
    assign bus.send_en = send_en_q;
    assign bus.busy    = busy_q;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .wr_en    (bus.wr_en),
        .wr_data  (bus.wr_data),
        .rd_en    (pop),
        .rd_data  (bus.tx_data),
        .full     (bus.full),
        .empty    (fifo_empty),
        .level    (bus.level),
        .overflow (bus.overflow)
    );

    // Send sequencer: pop and pulse send_en from IDLE, then hold until Tx_Done.
    always_comb begin
        state_d   = state_q;
        send_en_d = 1'b0;
        busy_d    = busy_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    send_en_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.Tx_Done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and its registered outputs; reset aborts any frame in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            send_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            send_en_q <= send_en_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model and a data
// scoreboard that is drained whenever the DUT pulses send_en.
module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic Clk;
    logic Rst_n;

    uart_tx_buffer_if #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) bus ();

    uart_tx_buffer dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int sendCount = 0;

    // Reference model state: number of stored words, word in flight, outputs.
    int         mLevel = 0;
    bit         mBusy  = 1'b0;
    bit         mSend  = 1'b0;
    bit         mOvf   = 1'b0;
    logic [7:0] mTx    = 8'h00;
    logic [7:0] modelQ[$];
    logic [7:0] sbQ[$];

    // Free-running clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic txd);
        @(negedge Clk);
        bus.wr_en   = wr;
        bus.wr_data = data;
        bus.Tx_Done = txd;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic sampleAfterEdge();
        @(posedge Clk);
        #1;
    endtask

    // Answers every handed-off word with Tx_Done a few cycles later until the model is empty.
    task automatic drainFifo(input int budget);
        int cnt = 0;
        int i;
        for (i = 0; i < budget; i++) begin
            if (mLevel == 0 && !mBusy) break;
            @(negedge Clk);
            bus.wr_en = 1'b0;
            if (bus.busy) cnt++;
            else cnt = 0;
            bus.Tx_Done = (cnt >= 3);
            if (cnt >= 3) cnt = 0;
        end
        if (i == budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout: level %0d busy %0d after %0d cycles", mLevel, mBusy, budget);
        end
        @(negedge Clk);
        bus.Tx_Done = 1'b0;
    endtask

    // Model step at each rising edge, then compare all outputs just after the edge.
    initial begin
        forever begin
            @(posedge Clk);
            if (!Rst_n) begin
                mLevel = 0;
                mBusy  = 1'b0;
                mSend  = 1'b0;
                mOvf   = 1'b0;
                mTx    = 8'h00;
                modelQ.delete();
                sbQ.delete();
            end else begin
                bit pop;
                bit acc;
                pop  = !mBusy && (mLevel > 0);
                acc  = bus.wr_en && ((mLevel < DEPTH) || pop);
                mOvf = bus.wr_en && !acc;
                mSend = pop;
                if (pop) begin
                    mTx   = modelQ.pop_front();
                    mBusy = 1'b1;
                end else if (mBusy && bus.Tx_Done) begin
                    mBusy = 1'b0;
                end
                if (acc) begin
                    modelQ.push_back(bus.wr_data);
                    sbQ.push_back(bus.wr_data);
                end
                mLevel = mLevel + int'(acc) - int'(pop);
            end
            #1;
            checkOutput("level",    32'(bus.level),    32'(mLevel));
            checkOutput("full",     32'(bus.full),     32'(mLevel == DEPTH));
            checkOutput("empty",    32'(bus.empty),    32'(mLevel == 0));
            checkOutput("overflow", 32'(bus.overflow), 32'(mOvf));
            checkOutput("send_en",  32'(bus.send_en),  32'(mSend));
            checkOutput("busy",     32'(bus.busy),     32'(mBusy));
            checkOutput("tx_data",  32'(bus.tx_data),  32'(mTx));
            if (bus.send_en === 1'b1) begin
                sendCount++;
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sbUnderflow: send_en with tx_data %0h, expected no send", bus.tx_data);
                end else begin
                    checkOutput("sbData", 32'(bus.tx_data), 32'(sbQ.pop_front()));
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int snap;
        Rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.Tx_Done = 1'b0;
        idleCycles(3);
        Rst_n = 1'b1;
        idleCycles(3);
        checkOutput("resetEmpty", 32'(bus.empty), 32'd1);
        checkOutput("resetBusy",  32'(bus.busy),  32'd0);

        // Single word latency and long Tx_Done delay.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        sampleAfterEdge();
        checkOutput("latEmpty",   32'(bus.empty),   32'd0);
        checkOutput("latSendEn0", 32'(bus.send_en), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        sampleAfterEdge();
        checkOutput("latSendEn1", 32'(bus.send_en), 32'd1);
        checkOutput("latTxData",  32'(bus.tx_data), 32'hA5);
        idleCycles(99);
        checkOutput("holdBusy",   32'(bus.busy),    32'd1);
        checkOutput("holdTxData", 32'(bus.tx_data), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1);
        sampleAfterEdge();
        checkOutput("doneBusy", 32'(bus.busy), 32'd0);

        // Tx_Done while idle and empty is ignored.
        applyStimulus(1'b0, 8'h00, 1'b1);
        sampleAfterEdge();
        checkOutput("idleDoneBusy", 32'(bus.busy),    32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        sampleAfterEdge();
        checkOutput("idleDoneSend", 32'(bus.send_en), 32'd0);

        // Fill to full behind a word in flight, then overflow.
        applyStimulus(1'b1, 8'hEE, 1'b0);
        idleCycles(3);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        sampleAfterEdge();
        checkOutput("fullLevel", 32'(bus.level), 32'd16);
        checkOutput("fullFlag",  32'(bus.full),  32'd1);
        applyStimulus(1'b1, 8'h99, 1'b0);
        sampleAfterEdge();
        checkOutput("ovfPulse", 32'(bus.overflow), 32'd1);
        checkOutput("ovfLevel", 32'(bus.level),    32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0);
        sampleAfterEdge();
        checkOutput("ovfClear", 32'(bus.overflow), 32'd0);

        // Write and pop together while full.
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h77, 1'b0);
        sampleAfterEdge();
        checkOutput("wpLevel",  32'(bus.level),    32'd16);
        checkOutput("wpOvf",    32'(bus.overflow), 32'd0);
        checkOutput("wpSend",   32'(bus.send_en),  32'd1);
        checkOutput("wpTxData", 32'(bus.tx_data),  32'h00);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Drain: words 0x01..0x0F then 0x77, in order.
        snap = sendCount;
        drainFifo(2000);
        checkOutput("drainCount", 32'(sendCount - snap), 32'd16);
        sampleAfterEdge();
        checkOutput("drainEmpty", 32'(bus.empty), 32'd1);

        // Reset in the middle of a frame with five words queued.
        applyStimulus(1'b1, 8'h11, 1'b0);
        idleCycles(3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        sampleAfterEdge();
        checkOutput("preRstLevel", 32'(bus.level), 32'd5);
        checkOutput("preRstBusy",  32'(bus.busy),  32'd1);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        checkOutput("rstSend",  32'(bus.send_en), 32'd0);
        checkOutput("rstBusy",  32'(bus.busy),    32'd0);
        checkOutput("rstLevel", 32'(bus.level),   32'd0);
        checkOutput("rstEmpty", 32'(bus.empty),   32'd1);
        idleCycles(3);
        Rst_n = 1'b1;
        snap = sendCount;
        idleCycles(20);
        checkOutput("postRstSends", 32'(sendCount - snap), 32'd0);

        // Randomized traffic: a write-heavy phase, then a balanced phase.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        drainFifo(3000);
        sampleAfterEdge();
        checkOutput("finalEmpty", 32'(bus.empty), 32'd1);
        checkOutput("finalSb",    32'(sbQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
